// File: rtl/full_add_4_pkg.sv
// ---------------------------------------------------------------------------
// full_add_4_pkg
// Shared constants and helpers for the small ripple-carry adder slice.
//   FA_WIDTH : default operand width of the adder (4 bits)
//   maj()    : three-input majority, the carry function of a full adder
// ---------------------------------------------------------------------------
package full_add_4_pkg;

   localparam int FA_WIDTH = 4;

   function automatic logic maj(input logic x, input logic y, input logic z);
      maj = (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/full_add_4_if.sv
// ---------------------------------------------------------------------------
// full_add_4_if
// Operand/result bundle of the 4-bit adder.
//   A, B, Cin     : operands and carry in (driven by the master)
//   Sum, Cout     : combinational result
//   Ovf           : combinational two's-complement overflow
//   Sum_q, Cout_q : result registered one clock later
// The master modport belongs to whoever supplies operands; the adder itself
// connects through the slave modport.
// ---------------------------------------------------------------------------
import full_add_4_pkg::*;

interface full_add_4_if #(parameter int WIDTH = FA_WIDTH);

   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Ovf;
   logic [WIDTH-1:0] Sum_q;
   logic             Cout_q;

   modport master (
      output A, B, Cin,
      input  Sum, Cout, Ovf, Sum_q, Cout_q
   );

   modport slave (
      input  A, B, Cin,
      output Sum, Cout, Ovf, Sum_q, Cout_q
   );

endinterface

// File: rtl/full_add_4_bit.sv
// ---------------------------------------------------------------------------
// full_add_1
// One-bit full adder, the cell the ripple-carry chain is built from.
//   a, b  : operand bits
//   cin   : carry in from the next lower bit
//   s     : sum bit
//   cout  : carry out to the next higher bit
// ---------------------------------------------------------------------------
import full_add_4_pkg::*;

module full_add_1 (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = maj(a, b, cin);

endmodule

// File: rtl/full_add_4.sv
// ---------------------------------------------------------------------------
// full_add_4
// 4-bit ripple-carry adder with a registered copy of its result.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears only the output register
//   bus   : full_add_4_if slave modport
//           in : A, B, Cin
//           out: Sum, Cout, Ovf (combinational), Sum_q, Cout_q (registered)
// {Cout,Sum} = A + B + Cin with no truncation of the 5-bit result.
// ---------------------------------------------------------------------------
import full_add_4_pkg::*;

module full_add_4 #(
   parameter int WIDTH = FA_WIDTH
) (
   input  logic clk,
   input  logic rst_n,
   full_add_4_if.slave bus
);

   // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum;

   assign c[0] = bus.Cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_add_1 u_fa (
         .a    (bus.A[i]),
         .b    (bus.B[i]),
         .cin  (c[i]),
         .s    (sum[i]),
         .cout (c[i+1])
      );
   end

   assign bus.Sum  = sum;
   assign bus.Cout = c[WIDTH];
   // signed overflow: carry into the MSB disagrees with carry out of it
   assign bus.Ovf  = c[WIDTH-1] ^ c[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.Sum_q  <= '0;
         bus.Cout_q <= 1'b0;
      end else begin
         bus.Sum_q  <= sum;
         bus.Cout_q <= c[WIDTH];
      end
   end

endmodule

// File: tb/tb_full_add_4.sv
// ---------------------------------------------------------------------------
// tb_full_add_4
// Self-checking bench for full_add_4: a directed vector table, an
// exhaustive sweep against an arithmetic model, and hand-written sequences
// for pipeline latency and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_full_add_4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   full_add_4_if #(.WIDTH(4)) bus ();

   full_add_4 #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs [10];

   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic cin);
      bus.A   = a;
      bus.B   = b;
      bus.Cin = cin;
   endtask

   task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
      end
   endtask

   initial begin
      int exp_full;
      int sa, sb, sres;
      logic [4:0] exp5;
      logic       exp_ovf;

      total = 0;
      bad   = 0;

      //          a      b      cin   sum       cout  ovf
      vecs[0] = '{4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[1] = '{4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[2] = '{4'd15, 4'd0,  1'b1, 4'b0000, 1'b1, 1'b0};
      vecs[3] = '{4'd7,  4'd1,  1'b0, 4'b1000, 1'b0, 1'b1};
      vecs[4] = '{4'd8,  4'd8,  1'b0, 4'b0000, 1'b1, 1'b1};
      vecs[5] = '{4'd3,  4'd2,  1'b0, 4'b0101, 1'b0, 1'b0};
      vecs[6] = '{4'd15, 4'd0,  1'b0, 4'b1111, 1'b0, 1'b0};
      vecs[7] = '{4'd9,  4'd6,  1'b1, 4'b0000, 1'b1, 1'b0};
      vecs[8] = '{4'd5,  4'd10, 1'b0, 4'b1111, 1'b0, 1'b0};
      vecs[9] = '{4'd6,  4'd5,  1'b1, 4'b1100, 1'b0, 1'b1};

      // reset state
      rst_n = 1'b0;
      applyStimulus(4'd0, 4'd0, 1'b0);
      #12;
      checkOutput("reset_sum_q",  {1'b0, bus.Sum_q}, 5'd0);
      checkOutput("reset_cout_q", {4'd0, bus.Cout_q}, 5'd0);

      // directed table
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
         #10;
         checkOutput($sformatf("vec%0d_sum", i),  {1'b0, bus.Sum}, {1'b0, vecs[i].sum});
         checkOutput($sformatf("vec%0d_cout", i), {4'd0, bus.Cout}, {4'd0, vecs[i].cout});
         checkOutput($sformatf("vec%0d_ovf", i),  {4'd0, bus.Ovf},  {4'd0, vecs[i].ovf});
      end

      // carry ripple: A=15,B=0, Cin 0->1->0
      applyStimulus(4'd15, 4'd0, 1'b0); #10;
      checkOutput("ripple0", {bus.Cout, bus.Sum}, 5'b01111);
      applyStimulus(4'd15, 4'd0, 1'b1); #10;
      checkOutput("ripple1", {bus.Cout, bus.Sum}, 5'b10000);
      applyStimulus(4'd15, 4'd0, 1'b0); #10;
      checkOutput("ripple2", {bus.Cout, bus.Sum}, 5'b01111);

      // exhaustive sweep against an integer model
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int ci = 0; ci < 2; ci++) begin
               applyStimulus(4'(a), 4'(b), 1'(ci));
               #10;
               exp_full = a + b + ci;
               exp5     = 5'(exp_full);
               sa       = (a > 7) ? a - 16 : a;
               sb       = (b > 7) ? b - 16 : b;
               sres     = sa + sb + ci;
               exp_ovf  = (sres > 7) || (sres < -8);
               checkOutput($sformatf("exh_%0d_%0d_%0d", a, b, ci), {bus.Cout, bus.Sum}, exp5);
               checkOutput($sformatf("exh_ovf_%0d_%0d_%0d", a, b, ci), {4'd0, bus.Ovf}, {4'd0, exp_ovf});
            end
         end
      end

      // registers stayed cleared while reset was held
      checkOutput("held_reset_sum_q", {bus.Cout_q, bus.Sum_q}, 5'd0);

      // pipeline latency
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(4'd5, 4'd2, 1'b0);
      @(posedge clk); #1;
      checkOutput("first_capture", {bus.Cout_q, bus.Sum_q}, 5'd7);
      @(negedge clk);
      applyStimulus(4'd9, 4'd6, 1'b1);
      #1;
      checkOutput("pipe_before_edge", {bus.Cout_q, bus.Sum_q}, 5'd7);
      checkOutput("pipe_comb_now", {bus.Cout, bus.Sum}, 5'b10000);
      @(posedge clk); #1;
      checkOutput("pipe_after_edge", {bus.Cout_q, bus.Sum_q}, 5'b10000);

      // async reset mid-run
      @(negedge clk);
      applyStimulus(4'd3, 4'd4, 1'b0);
      @(posedge clk); #1;
      checkOutput("pre_reset_q", {bus.Cout_q, bus.Sum_q}, 5'd7);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_clear_q", {bus.Cout_q, bus.Sum_q}, 5'd0);
      applyStimulus(4'd15, 4'd15, 1'b1);
      #1;
      checkOutput("comb_during_reset", {bus.Cout, bus.Sum}, 5'd31);
      @(posedge clk); #1;
      checkOutput("q_held_in_reset", {bus.Cout_q, bus.Sum_q}, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("q_before_reload", {bus.Cout_q, bus.Sum_q}, 5'd0);
      @(posedge clk); #1;
      checkOutput("q_reload", {bus.Cout_q, bus.Sum_q}, 5'd31);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
